// File: rtl/jk_drv_pkg.sv
// rtl/jk_drv_pkg.sv - shared state and JK excitation encodings for the JK drive controller
package jk_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  // {J,K} pairs as presented to one flop
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_excite.sv
// rtl/jk_excite.sv - per-bit JK excitation from current state and target
module jk_excite
  import jk_drv_pkg::*;
#(
  parameter int PREFER_TOGGLE = 1
) (
  input  logic       i_q,
  input  logic       i_t,
  output logic [1:0] o_jk
);

  always_comb begin
    o_jk = JK_HOLD;
    if (i_q != i_t) begin
      if (PREFER_TOGGLE != 0) o_jk = JK_TGL;
      else                    o_jk = i_t ? JK_SET : JK_RST;
    end
  end

endmodule

// File: rtl/jk_drive_ctrl.sv
// rtl/jk_drive_ctrl.sv - drives a JK flop bank to a requested word for one cycle, then optionally verifies it
module jk_drive_ctrl
  import jk_drv_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int PREFER_TOGGLE = 1,
  parameter int CHECK_EN      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask,
  input  logic             err_clr,
  output logic [7:0]       err_count
);

  localparam bit LP_CHECK = (CHECK_EN != 0);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_mask;
  logic [7:0]       r_count;

  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_mismatch;
  logic             w_accept;
  logic             w_chk_fail;

  for (genvar g = 0; g < WIDTH; g++) begin : g_excite
    logic [1:0] w_jk;
    jk_excite #(.PREFER_TOGGLE(PREFER_TOGGLE)) u_excite (
      .i_q  (q_fb[g]),
      .i_t  (req_target[g]),
      .o_jk (w_jk)
    );
    assign w_j[g] = w_jk[1];
    assign w_k[g] = w_jk[0];
  end

  assign w_accept   = (r_state == IDLE) && req_valid;
  assign w_mismatch = q_fb ^ r_target;
  assign w_chk_fail = (r_state == CHECK) && (|w_mismatch);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = DRIVE;
      DRIVE:   w_next = LP_CHECK ? CHECK : IDLE;
      CHECK:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Excitation is registered at acceptance so J/K are live only during DRIVE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_target <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_mask   <= '0;
      r_count  <= '0;
    end else begin
      r_j    <= '0;
      r_k    <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_accept) begin
        r_target <= req_target;
        r_j      <= w_j;
        r_k      <= w_k;
      end
      if ((r_state == DRIVE) && !LP_CHECK) r_done <= 1'b1;
      if (r_state == CHECK) begin
        r_mask <= w_mismatch;
        r_done <= 1'b1;
        r_err  <= |w_mismatch;
      end
      if (err_clr)                              r_count <= '0;
      else if (w_chk_fail && (r_count != 8'hFF)) r_count <= r_count + 8'd1;
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign j_out     = r_j;
  assign k_out     = r_k;
  assign done      = r_done;
  assign err       = r_err;
  assign err_mask  = r_mask;
  assign err_count = r_count;

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// tb/tb_jk_drive_ctrl.sv - self-checking bench for jk_drive_ctrl across toggle, set/reset and no-check builds
module tb_jk_drive_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid [3];
  logic       req_ready [3];
  logic [7:0] req_target[3];
  logic [7:0] j_out     [3];
  logic [7:0] k_out     [3];
  logic       busy      [3];
  logic       done      [3];
  logic       err       [3];
  logic [7:0] err_mask  [3];
  logic       err_clr   [3];
  logic [7:0] err_count [3];

  logic       load_en [3];
  logic [7:0] load_val[3];
  logic [7:0] stuck   [3];
  logic [7:0] bank    [3];

  int n_chk  = 0;
  int n_fail = 0;
  int cnt[3];

  always #5 clk = ~clk;

  // Instance 0: toggle+check, 1: set/reset+check, 2: toggle, no check
  for (genvar g = 0; g < 3; g++) begin : g_dut
    jk_drive_ctrl #(
      .WIDTH(8),
      .PREFER_TOGGLE((g == 1) ? 0 : 1),
      .CHECK_EN((g == 2) ? 0 : 1)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_target (req_target[g]),
      .q_fb       (bank[g]),
      .j_out      (j_out[g]),
      .k_out      (k_out[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .err        (err[g]),
      .err_mask   (err_mask[g]),
      .err_clr    (err_clr[g]),
      .err_count  (err_count[g])
    );
  end

  // JK flop bank with optional stuck-at-0 bits
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (load_en[u]) bank[u] <= load_val[u] & ~stuck[u];
      else            bank[u] <= ((j_out[u] & ~bank[u]) | (~k_out[u] & bank[u])) & ~stuck[u];
    end
  end

  typedef struct {
    logic [7:0] init;
    logic [7:0] tgt;
    logic [7:0] stk;
    logic [7:0] ej;
    logic [7:0] ek;
    logic [7:0] efin;
    logic [7:0] emask;
    bit         eerr;
    logic [7:0] ecnt;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_op(input int u, input logic [7:0] init, input logic [7:0] tgt,
                       input logic [7:0] stk, input bit clr, input logic [7:0] ej,
                       input logic [7:0] ek, input logic [7:0] efin, input logic [7:0] emask,
                       input bit eerr, input logic [7:0] ecnt);
    @(negedge clk);
    load_en[u] = 1'b1; load_val[u] = init; stuck[u] = stk;
    @(negedge clk);
    load_en[u] = 1'b0;
    chk($sformatf("u%0d ready_idle", u), req_ready[u], 1);
    chk($sformatf("u%0d busy_idle", u), busy[u], 0);
    req_valid[u] = 1'b1; req_target[u] = tgt;
    @(negedge clk);
    req_valid[u] = 1'b0; req_target[u] = 8'($urandom);
    chk($sformatf("u%0d j_drive", u), j_out[u], ej);
    chk($sformatf("u%0d k_drive", u), k_out[u], ek);
    chk($sformatf("u%0d busy_drive", u), busy[u], 1);
    chk($sformatf("u%0d ready_drive", u), req_ready[u], 0);
    chk($sformatf("u%0d done_drive", u), done[u], 0);
    @(negedge clk);
    chk($sformatf("u%0d bank_final", u), bank[u], efin);
    if (u != 2) begin
      chk($sformatf("u%0d j_check", u), j_out[u], 0);
      chk($sformatf("u%0d k_check", u), k_out[u], 0);
      chk($sformatf("u%0d busy_check", u), busy[u], 1);
      chk($sformatf("u%0d done_check", u), done[u], 0);
      err_clr[u] = clr;
      @(negedge clk);
      err_clr[u] = 1'b0;
    end
    chk($sformatf("u%0d done", u), done[u], 1);
    chk($sformatf("u%0d err", u), err[u], eerr);
    chk($sformatf("u%0d err_mask", u), err_mask[u], emask);
    chk($sformatf("u%0d err_count", u), err_count[u], ecnt);
    chk($sformatf("u%0d ready_done", u), req_ready[u], 1);
    chk($sformatf("u%0d busy_done", u), busy[u], 0);
    @(negedge clk);
    chk($sformatf("u%0d done_pulse", u), done[u], 0);
    chk($sformatf("u%0d err_pulse", u), err[u], 0);
  endtask

  // Reference: bank lands on target except stuck bits; set/reset build drives only the needed side
  task automatic run_model(input int u, input logic [7:0] init, input logic [7:0] tgt,
                           input logic [7:0] stk, input bit clr);
    logic [7:0] q, d, ej, ek, efin, emask;
    bit eerr;
    q     = init & ~stk;
    d     = q ^ tgt;
    ej    = (u == 1) ? (d & tgt) : d;
    ek    = (u == 1) ? (d & ~tgt) : d;
    efin  = tgt & ~stk;
    emask = (u == 2) ? 8'h00 : (tgt & stk);
    eerr  = (emask != 8'h00);
    if (clr)                      cnt[u] = 0;
    else if (eerr && cnt[u] < 255) cnt[u] = cnt[u] + 1;
    do_op(u, init, tgt, stk, clr, ej, ek, efin, emask, eerr, 8'(cnt[u]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tg[3];
    logic [7:0] df[3];
    int         u;
    tg[0] = 8'h01; tg[1] = 8'h03; tg[2] = 8'h07;
    df[0] = 8'h01; df[1] = 8'h02; df[2] = 8'h04;

    tbl[0] = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'hFF, 8'h5A, 8'h00, 1'b0, 8'd0};
    tbl[1] = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08, 1'b1, 8'd1};
    tbl[2] = '{8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 1'b0, 8'd1};
    tbl[3] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 8'd1};
    tbl[4] = '{8'h00, 8'hFF, 8'h81, 8'hFF, 8'hFF, 8'h7E, 8'h81, 1'b1, 8'd2};

    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_target[i] = 8'h00; err_clr[i] = 1'b0;
      load_en[i] = 1'b1; load_val[i] = 8'h00; stuck[i] = 8'h00; cnt[i] = 0;
    end

    repeat (2) @(negedge clk);
    chk("reset j_out", j_out[0], 0);
    chk("reset k_out", k_out[0], 0);
    chk("reset done", done[0], 0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      load_en[i] = 1'b0;
      chk($sformatf("u%0d reset ready", i), req_ready[i], 1);
      chk($sformatf("u%0d reset busy", i), busy[i], 0);
      chk($sformatf("u%0d reset err", i), err[i], 0);
      chk($sformatf("u%0d reset mask", i), err_mask[i], 0);
      chk($sformatf("u%0d reset count", i), err_count[i], 0);
    end

    for (int i = 0; i < 5; i++)
      do_op(0, tbl[i].init, tbl[i].tgt, tbl[i].stk, 1'b0, tbl[i].ej, tbl[i].ek,
            tbl[i].efin, tbl[i].emask, tbl[i].eerr, tbl[i].ecnt);
    cnt[0] = 2;

    // Reset in the middle of DRIVE
    @(negedge clk);
    load_en[0] = 1'b1; load_val[0] = 8'h5A; stuck[0] = 8'h00;
    @(negedge clk);
    load_en[0] = 1'b0; req_valid[0] = 1'b1; req_target[0] = 8'hA5;
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("rstmid j_before", j_out[0], 8'hFF);
    #2 rst = 1'b0;
    #1;
    chk("rstmid j_async", j_out[0], 0);
    chk("rstmid k_async", k_out[0], 0);
    chk("rstmid busy", busy[0], 0);
    @(negedge clk);
    chk("rstmid done_in_reset", done[0], 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid done_after", done[0], 0);
    chk("rstmid ready", req_ready[0], 1);
    chk("rstmid count", err_count[0], 0);
    chk("rstmid bank_untouched", bank[0], 8'h5A);
    for (int i = 0; i < 3; i++) cnt[i] = 0;

    // Set/reset build: 0F -> F0
    do_op(1, 8'h0F, 8'hF0, 8'h00, 1'b0, 8'hF0, 8'h0F, 8'hF0, 8'h00, 1'b0, 8'd0);

    // Back-to-back requests on the no-check build
    @(negedge clk);
    load_en[2] = 1'b1; load_val[2] = 8'h00; stuck[2] = 8'h00;
    @(negedge clk);
    load_en[2] = 1'b0; req_valid[2] = 1'b1; req_target[2] = tg[0];
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b ready %0d", i), req_ready[2], 1);
      chk($sformatf("b2b done_at_accept %0d", i), done[2], (i > 0) ? 1 : 0);
      @(negedge clk);
      chk($sformatf("b2b ready_drive %0d", i), req_ready[2], 0);
      chk($sformatf("b2b j %0d", i), j_out[2], df[i]);
      chk($sformatf("b2b k %0d", i), k_out[2], df[i]);
      chk($sformatf("b2b done_drive %0d", i), done[2], 0);
      if (i < 2) req_target[2] = tg[i+1];
      @(negedge clk);
    end
    chk("b2b done_last", done[2], 1);
    chk("b2b bank", bank[2], 8'h07);
    chk("b2b mask", err_mask[2], 0);
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("b2b idle", busy[2], 0);

    // Saturation then clear colliding with an err pulse
    for (int i = 0; i < 256; i++) run_model(0, 8'h00, 8'h01, 8'h01, 1'b0);
    chk("sat count", err_count[0], 8'd255);
    run_model(0, 8'h00, 8'h01, 8'h01, 1'b1);
    chk("clr count", err_count[0], 0);

    // Randomized operations against the reference
    for (int i = 0; i < 60; i++) begin
      u = $urandom_range(0, 2);
      run_model(u, 8'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                (u != 2) && ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_drive_ctrl.md
Name: jk_drive_ctrl

Overview:
- Drives a bank of WIDTH JK flip-flops from their current state to a requested target word.
- Computes J/K excitation per bit from the excitation table and applies it for exactly one clock.
- Optionally checks the flop feedback afterwards and reports per-bit mismatches plus a saturating error count.
- Sits between register-update logic (valid/ready requester) and a JK flip-flop register bank sharing clk.

Parameters:
- WIDTH, 8, number of JK flip-flops driven.
- PREFER_TOGGLE, 1, don't-care resolution: 1 = use JK=11 for any bit change; 0 = use JK=10 (set) / JK=01 (reset).
- CHECK_EN, 1, 1 = insert CHECK cycle comparing feedback to target; 0 = no check, err never asserts.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  target request valid.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_target  in  WIDTH  desired next flop state.
- q_fb  in  WIDTH  current Q of the driven flop bank.
- j_out  out  WIDTH  J inputs to flop bank.
- k_out  out  WIDTH  K inputs to flop bank.
- busy  out  1  high in DRIVE or CHECK.
- done  out  1  one-cycle pulse when an operation completes.
- err  out  1  one-cycle pulse with done when feedback mismatches target.
- err_mask  out  WIDTH  bits that mismatched; held until the next done.
- err_clr  in  1  synchronous clear of err_count.
- err_count  out  8  saturating count of failed operations.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; j_out=k_out=0 (hold, flop bank untouched); req_ready=1 once rst releases; busy=done=err=0; err_mask=0; err_count=0; captured target=0.
- Excitation per bit, from snapshot q_fb at acceptance (q) and target (t):
  - q=t: JK=00.
  - q=0,t=1: JK=11 if PREFER_TOGGLE else 10.
  - q=1,t=0: JK=11 if PREFER_TOGGLE else 01.
- FSM states:
  - IDLE: req_ready=1, J/K=0. On req_valid&&req_ready at edge E0: register target; register excitation from q_fb sampled at E0; go DRIVE.
  - DRIVE (cycle after E0): j_out/k_out hold the registered excitation for exactly this cycle; flop bank updates at E1. Next state is CHECK if CHECK_EN, else IDLE with done=1.
  - CHECK (cycle after E1): J/K=0. At E2, compare q_fb to target; load err_mask=q_fb^target; set done=1 and err=|mask; go IDLE.
- Latency:
  - CHECK_EN=1: done visible 3 cycles after acceptance cycle (after E2); req_ready high in the same cycle. Back-to-back throughput is one request per 3 cycles.
  - CHECK_EN=0: done after E1; one request per 2 cycles.
- All outputs are registered; no combinational path from q_fb or req_* to outputs except req_ready, which is decoded from state.
- Target equal to q_fb: still performs DRIVE with JK=00; done pulses, err=0.
- req_valid while busy: ignored (ready low); the requester must hold valid.
- err_count: increments by 1 on each err pulse and saturates at 255. err_clr clears it; err_clr takes priority over a simultaneous increment, which is dropped.
- rst asserted mid-DRIVE: J/K drop to 0 immediately (asynchronous); the operation is abandoned with no done pulse.
- CHECK_EN=0: err_mask stays 0.

Decomposition:
- Package jk_drv_pkg:
  - state enum {IDLE, DRIVE, CHECK}.
  - JK encoding constants JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11.
- Sub-module jk_excite: combinational per-bit mapping (q, t, PREFER_TOGGLE) -> {j,k}, instantiated WIDTH times via generate. The FSM, capture registers and error counter stay in jk_drive_ctrl.

Test Plan:
- Reset mid-DRIVE: rst low during DRIVE -> j_out/k_out=0 immediately, no done; after release req_ready=1 and err_count=0.
- Set/reset mode (PREFER_TOGGLE=0), bench JK bank at 8'h0F: request 8'hF0 -> DRIVE has j_out=8'hF0, k_out=8'h0F; bank reads 8'hF0; done=1, err=0 exactly 3 cycles after acceptance.
- Toggle mode (PREFER_TOGGLE=1), bank at 8'hA5: request 8'h5A -> j_out=k_out=8'hFF for one cycle; bank reads 8'h5A; err=0.
- Fault injection: bank bit 3 stuck at 0, q=8'h00, request 8'h08 -> err=1, err_mask=8'h08, err_count 0->1.
- Saturation and clear: 256 forced failures -> err_count=255 and holds at 255; err_clr together with an err pulse -> err_count=0.
- Back-to-back with CHECK_EN=0: req_valid held high with targets 8'h01, 8'h03, 8'h07 -> each accepted 2 cycles apart, done pulses every 2 cycles, final bank state 8'h07.
